mem_access_unit: RTL and testbench

Parametrised successor to the single-cycle memory access stage. It accepts one load or store per handshake and performs it against an internal byte-addressed, little-endian data array. Supported sizes are byte, half, word and double, with sign or zero extension, a configurable access latency and misalignment detection. It sits between execute and writeback, and back-pressures execute through `in_ready`.

---
 rtl/mem_access_pkg.sv | 43 ++++
 rtl/mem_access_if.sv | 30 +++
 rtl/byte_lane_memory.sv | 39 +++
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access stage.
//   - funct3 size/sign codes
//   - FSM state encoding
//   - size_decode(): funct3 -> access byte count and sign-extension flag
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] nbytes;     // 0 marks a reserved code
    logic       is_signed;
  } size_info_t;

  function automatic size_info_t size_decode(input logic [2:0] f3);
    size_info_t s;
    s.nbytes    = 4'd0;
    s.is_signed = 1'b0;
    case (f3)
      F3_B:    begin s.nbytes = 4'd1; s.is_signed = 1'b1; end
      F3_H:    begin s.nbytes = 4'd2; s.is_signed = 1'b1; end
      F3_W:    begin s.nbytes = 4'd4; s.is_signed = 1'b1; end
      F3_D:    begin s.nbytes = 4'd8; s.is_signed = 1'b0; end
      F3_BU:   begin s.nbytes = 4'd1; s.is_signed = 1'b0; end
      F3_HU:   begin s.nbytes = 4'd2; s.is_signed = 1'b0; end
      F3_WU:   begin s.nbytes = 4'd4; s.is_signed = 1'b0; end
      default: begin s.nbytes = 4'd0; s.is_signed = 1'b0; end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/response bundle between execute, the memory access unit and writeback.
//   master: drives the request (in_valid, mem_read, mem_write, funct3, alu_result,
//           write_data) and out_ready; observes in_ready and the response.
//   slave:  the memory access unit.
interface mem_access_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic            mem_read;
  logic            mem_write;
  logic [2:0]      funct3;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] write_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] mem_data;
  logic            misaligned;
  logic            err;

  modport master (
    output in_valid, mem_read, mem_write, funct3, alu_result, write_data, out_ready,
    input  in_ready, out_valid, mem_data, misaligned, err
  );

  modport slave (
    input  in_valid, mem_read, mem_write, funct3, alu_result, write_data, out_ready,
    output in_ready, out_valid, mem_data, misaligned, err
  );
endinterface

// File: rtl/byte_lane_memory.sv
// Byte-addressed data array of 2^ADDR_W bytes, contents not reset.
//   clk   : write clock
//   we    : write strobe, qualified per lane by be
//   be    : XLEN/8 byte enables, lane i targets addr+i
//   addr  : start byte address (wraps modulo 2^ADDR_W)
//   wdata : lane i carries wdata[8i+7:8i]
//   rdata : combinational little-endian read of XLEN/8 bytes from addr
module byte_lane_memory #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [XLEN/8-1:0] be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);
  localparam int unsigned Lanes = XLEN / 8;
  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [7:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < Lanes; i++) begin
      if (we && be[i]) begin
        mem_q[addr + ADDR_W'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      rdata[8*i +: 8] = mem_q[addr + ADDR_W'(i)];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit between execute and writeback.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mem_access_if (request in, response out)
// One request is accepted in IDLE, waits MEM_LATENCY cycles in BUSY, and its
// response is held in RESP until writeback takes it.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_access_if.slave bus
);
  localparam int unsigned Lanes = XLEN / 8;
  localparam int unsigned CntW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Registered request
  logic              read_q, write_q, req_err_q, req_mis_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;

  // Registered response
  logic [XLEN-1:0]   resp_data_q;
  logic              resp_mis_q, resp_err_q;

  size_info_t        in_size, ld_size;
  logic              in_err, in_mis, accept, commit, access_ok;
  logic [2:0]        align_mask;
  logic [Lanes-1:0]  be;
  logic [XLEN-1:0]   rdata, ld_data;
  logic              sbit;
  int unsigned       ld_nbits;
  logic              unused_bits;

  // Request checks on the incoming fields
  always_comb begin
    in_size    = size_decode(bus.funct3);
    in_err     = (in_size.nbytes == 4'd0)
              || ((XLEN == 32) && ((bus.funct3 == F3_D) || (bus.funct3 == F3_WU)))
              || (bus.mem_read && bus.mem_write)
              || (bus.mem_write && bus.funct3[2]);
    // nbytes of 8 truncates to 0 in three bits, so the mask becomes 3'b111
    align_mask = in_size.nbytes[2:0] - 3'd1;
    in_mis     = !in_err && (bus.mem_read || bus.mem_write)
              && ((bus.alu_result[2:0] & align_mask) != 3'd0);
  end

  assign unused_bits = ^{bus.alu_result[XLEN-1:ADDR_W], in_size.is_signed};

  assign accept    = bus.in_valid && (state_q == StIdle);
  // Final BUSY cycle: the store commits and the response is captured here
  assign commit    = (state_q == StBusy) && (cnt_q == '0);
  assign access_ok = !req_err_q && !req_mis_q;

  always_comb begin
    ld_size  = size_decode(f3_q);
    ld_nbits = {28'd0, ld_size.nbytes} << 3;
    be       = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      be[i] = (i < {28'd0, ld_size.nbytes});
    end
  end

  byte_lane_memory #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (commit && write_q && access_ok),
    .be    (be),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  // Sign or zero extension of the read bytes
  always_comb begin
    case (ld_size.nbytes)
      4'd1:    sbit = rdata[7];
      4'd2:    sbit = rdata[15];
      4'd4:    sbit = rdata[31];
      default: sbit = rdata[XLEN-1];
    endcase
    ld_data = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      ld_data[i] = (i < ld_nbits) ? rdata[i] : (ld_size.is_signed & sbit);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = StBusy;
          cnt_d   = CntLoad;
        end
      end
      StBusy: begin
        if (cnt_q == '0) state_d = StResp;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StResp: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      req_err_q   <= 1'b0;
      req_mis_q   <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      resp_mis_q  <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        read_q    <= bus.mem_read;
        write_q   <= bus.mem_write;
        req_err_q <= in_err;
        req_mis_q <= in_mis;
        f3_q      <= bus.funct3;
        addr_q    <= bus.alu_result[ADDR_W-1:0];
        wdata_q   <= bus.write_data;
      end
      if (commit) begin
        resp_data_q <= (read_q && access_ok) ? ld_data : '0;
        resp_mis_q  <= req_mis_q;
        resp_err_q  <= req_err_q;
      end
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.out_valid  = (state_q == StResp);
  assign bus.mem_data   = resp_data_q;
  assign bus.misaligned = resp_mis_q;
  assign bus.err        = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with default parameters. A byte-array
// reference model computes expected load data, misaligned and err flags.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [1024];

  always #5 clk = ~clk;

  mem_access_if #(.XLEN(64)) bus ();

  mem_access_unit #(
    .XLEN        (64),
    .ADDR_W      (10),
    .MEM_LATENCY (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: apply one request to ref_mem and return the expected response
  function automatic void model(input logic r, input logic w, input logic [2:0] f3,
                                input logic [63:0] a, input logic [63:0] wd,
                                output logic [63:0] d, output logic m, output logic e);
    int n;
    int idx;
    logic [63:0] val;
    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2, 3'd6: n = 4;
      3'd3:       n = 8;
      default:    n = 0;
    endcase
    e = (f3 == 3'd7) || (r && w) || (w && (f3 >= 3'd4));
    idx = int'(a % 64'd1024);
    m = !e && (r || w) && (n != 0) && ((idx % n) != 0);
    d = 64'd0;
    if (!e && !m) begin
      if (w) for (int k = 0; k < n; k++) ref_mem[(idx + k) % 1024] = wd[8*k +: 8];
      if (r) begin
        val = 64'd0;
        for (int k = 0; k < n; k++) val[8*k +: 8] = ref_mem[(idx + k) % 1024];
        if ((f3 < 3'd3) && val[8*n-1]) for (int b = 8 * n; b < 64; b++) val[b] = 1'b1;
        d = val;
      end
    end
  endfunction

  // Drive one request from idle, return the response, the cycles from accept to
  // out_valid, and in_ready after the response handshake.
  task automatic xact(input logic r, input logic w, input logic [2:0] f3,
                      input logic [63:0] a, input logic [63:0] wd,
                      output logic [63:0] d, output logic m, output logic e,
                      output int lat, output logic rdy);
    bus.mem_read = r; bus.mem_write = w; bus.funct3 = f3;
    bus.alu_result = a; bus.write_data = wd; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.out_valid && lat < 20);
    d = bus.mem_data; m = bus.misaligned; e = bus.err;
    if (bus.out_ready) begin @(posedge clk); #1; end
    rdy = bus.in_ready;
    $display("xact %s f3=%0d addr=%h wdata=%h data=%h mis=%b err=%b",
             w ? "store" : (r ? "load" : "nop"), f3, a, wd, d, m, e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.mem_data !== 64'd0) begin errors++; $display("FAIL rst_mem_data got %h want 0", bus.mem_data); end
    checks++; if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL rst_misaligned got %b want 0", bus.misaligned); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", bus.err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Give every byte a known random value
  task automatic test_fill();
    logic [63:0] d, ed, wd; logic m, e, em, ee, rdy; int lat;
    for (int a = 0; a < 1024; a += 8) begin
      wd = {$urandom, $urandom};
      model(1'b0, 1'b1, 3'd3, 64'(a), wd, ed, em, ee);
      xact(1'b0, 1'b1, 3'd3, 64'(a), wd, d, m, e, lat, rdy);
      checks++;
      if ({d, m, e} !== {ed, em, ee} || lat != 2 || rdy !== 1'b1) begin
        errors++; $display("FAIL fill_sd@%0h got %h/%b/%b lat %0d want %h/%b/%b lat 2", a, d, m, e, lat, ed, em, ee);
      end
    end
  endtask

  task automatic test_directed();
    logic [63:0] d, ed; logic m, e, em, ee, rdy; int lat;
    model(1'b0, 1'b1, 3'd3, 64'h40, 64'h1122334455667788, ed, em, ee);
    xact(1'b0, 1'b1, 3'd3, 64'h40, 64'h1122334455667788, d, m, e, lat, rdy);
    checks++; if (lat != 2) begin errors++; $display("FAIL sd_latency got %0d want 2", lat); end
    model(1'b1, 1'b0, 3'd3, 64'h40, 64'd0, ed, em, ee);
    xact(1'b1, 1'b0, 3'd3, 64'h40, 64'd0, d, m, e, lat, rdy);
    checks++; if (d !== 64'h1122334455667788) begin errors++; $display("FAIL ld_40 got %h want 1122334455667788", d); end
    checks++; if (lat != 2) begin errors++; $display("FAIL ld_latency got %0d want 2", lat); end
    model(1'b0, 1'b1, 3'd0, 64'h41, 64'h80, ed, em, ee);
    xact(1'b0, 1'b1, 3'd0, 64'h41, 64'h80, d, m, e, lat, rdy);
    model(1'b1, 1'b0, 3'd0, 64'h41, 64'd0, ed, em, ee);
    xact(1'b1, 1'b0, 3'd0, 64'h41, 64'd0, d, m, e, lat, rdy);
    checks++; if (d !== 64'hFFFFFFFFFFFFFF80) begin errors++; $display("FAIL lb_41 got %h want ffffffffffffff80", d); end
    model(1'b1, 1'b0, 3'd4, 64'h41, 64'd0, ed, em, ee);
    xact(1'b1, 1'b0, 3'd4, 64'h41, 64'd0, d, m, e, lat, rdy);
    checks++; if (d !== 64'h80) begin errors++; $display("FAIL lbu_41 got %h want 80", d); end
    model(1'b1, 1'b0, 3'd3, 64'h40, 64'd0, ed, em, ee);
    xact(1'b1, 1'b0, 3'd3, 64'h40, 64'd0, d, m, e, lat, rdy);
    checks++; if (d !== 64'h1122334455668088) begin errors++; $display("FAIL ld_after_sb got %h want 1122334455668088", d); end
    // Misaligned load and store, reserved funct3, read+write, store with load-only code
    xact(1'b1, 1'b0, 3'd2, 64'h42, 64'd0, d, m, e, lat, rdy);
    checks++; if ({d, m, e} !== {64'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL lw_misaligned got %h/%b/%b want 0/1/0", d, m, e); end
    xact(1'b0, 1'b1, 3'd2, 64'h42, 64'hCAFEF00D, d, m, e, lat, rdy);
    checks++; if ({d, m, e} !== {64'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL sw_misaligned got %h/%b/%b want 0/1/0", d, m, e); end
    xact(1'b1, 1'b0, 3'd3, 64'h40, 64'd0, d, m, e, lat, rdy);
    checks++; if (d !== 64'h1122334455668088) begin errors++; $display("FAIL array_unchanged got %h want 1122334455668088", d); end
    xact(1'b1, 1'b0, 3'd7, 64'h40, 64'd0, d, m, e, lat, rdy);
    checks++; if ({d, m, e} !== {64'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL f3_reserved got %h/%b/%b want 0/0/1", d, m, e); end
    xact(1'b1, 1'b1, 3'd3, 64'h43, 64'h99, d, m, e, lat, rdy);
    checks++; if ({d, m, e} !== {64'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL rd_and_wr got %h/%b/%b want 0/0/1", d, m, e); end
    xact(1'b0, 1'b1, 3'd4, 64'h40, 64'h77, d, m, e, lat, rdy);
    checks++; if ({d, m, e} !== {64'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL store_lbu_code got %h/%b/%b want 0/0/1", d, m, e); end
    xact(1'b0, 1'b0, 3'd3, 64'h40, 64'h77, d, m, e, lat, rdy);
    checks++; if ({d, m, e, lat} !== {64'd0, 1'b0, 1'b0, 32'd2}) begin errors++; $display("FAIL nop got %h/%b/%b lat %0d want 0/0/0 lat 2", d, m, e, lat); end
    xact(1'b1, 1'b0, 3'd3, 64'h40, 64'd0, d, m, e, lat, rdy);
    checks++; if (d !== 64'h1122334455668088) begin errors++; $display("FAIL after_errors got %h want 1122334455668088", d); end
  endtask

  task automatic test_hold();
    logic [63:0] ed; logic em, ee; int n;
    model(1'b1, 1'b0, 3'd3, 64'h40, 64'd0, ed, em, ee);
    bus.out_ready = 1'b0;
    bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.funct3 = 3'd3;
    bus.alu_result = 64'h40; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.mem_read = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.mem_data !== ed || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_cycle%0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=0", c, bus.out_valid, bus.mem_data, bus.in_ready, ed);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] d, ed; logic m, e, em, ee, rdy; int lat;
    model(1'b0, 1'b1, 3'd2, 64'h440, 64'hDEADBEEF, ed, em, ee);
    xact(1'b0, 1'b1, 3'd2, 64'h440, 64'hDEADBEEF, d, m, e, lat, rdy);
    model(1'b1, 1'b0, 3'd6, 64'h40, 64'd0, ed, em, ee);
    xact(1'b1, 1'b0, 3'd6, 64'h40, 64'd0, d, m, e, lat, rdy);
    checks++; if (d !== 64'hDEADBEEF) begin errors++; $display("FAIL wrap_lwu got %h want deadbeef", d); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d, ed; logic m, e, em, ee, rdy; int lat;
    bus.mem_read = 1'b0; bus.mem_write = 1'b1; bus.funct3 = 3'd3;
    bus.alu_result = 64'h80; bus.write_data = 64'h55; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.mem_write = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.mem_data, bus.misaligned, bus.err} !== {1'b1, 1'b0, 64'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midrst_outputs got rdy=%b v=%b d=%h m=%b e=%b want 1/0/0/0/0", bus.in_ready, bus.out_valid, bus.mem_data, bus.misaligned, bus.err);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    model(1'b1, 1'b0, 3'd3, 64'h80, 64'd0, ed, em, ee);
    xact(1'b1, 1'b0, 3'd3, 64'h80, 64'd0, d, m, e, lat, rdy);
    checks++; if (d !== ed) begin errors++; $display("FAIL midrst_store_dropped got %h want %h", d, ed); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d, ed, a, wd; logic m, e, em, ee, rdy; int lat;
    for (int i = 0; i < 20; i++) begin
      a = 64'($urandom_range(0, 255)) << 2;
      wd = {$urandom, $urandom};
      model(1'b0, 1'b1, 3'd2, a, wd, ed, em, ee);
      xact(1'b0, 1'b1, 3'd2, a, wd, d, m, e, lat, rdy);
      model(1'b1, 1'b0, 3'd2, a, 64'd0, ed, em, ee);
      xact(1'b1, 1'b0, 3'd2, a, 64'd0, d, m, e, lat, rdy);
      checks++; if (d !== ed) begin errors++; $display("FAIL b2b_lw@%h got %h want %h", a, d, ed); end
    end
  endtask

  task automatic test_random();
    logic [63:0] d, ed, a, wd; logic m, e, em, ee, rdy, r, w; logic [2:0] f3; int lat;
    for (int i = 0; i < 300; i++) begin
      {r, w} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) != 0) {r, w} = $urandom_range(0, 1) ? 2'b10 : 2'b01;
      f3 = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~64'h7;
      wd = {$urandom, $urandom};
      model(r, w, f3, a, wd, ed, em, ee);
      xact(r, w, f3, a, wd, d, m, e, lat, rdy);
      checks++;
      if ({d, m, e} !== {ed, em, ee} || lat != 2 || rdy !== 1'b1) begin
        errors++; $display("FAIL rand%0d r=%b w=%b f3=%0d a=%h got %h/%b/%b lat %0d rdy %b want %h/%b/%b lat 2 rdy 1",
                           i, r, w, f3, a, d, m, e, lat, rdy, ed, em, ee);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.funct3 = 3'd0;
    bus.alu_result = 64'd0; bus.write_data = 64'd0; bus.out_ready = 1'b1;
    test_reset();
    test_fill();
    test_directed();
    test_hold();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
